ex_stage_seq: RTL
=================

Name: ex_stage_seq

Overview:
Execute stage sitting directly downstream of the ID/EX pipeline register; consumes its control, operand and Func10 fields and feeds the EX/MEM register.
Performs operand forwarding, ALUSrc selection and single-cycle ALU ops.
Runs MUL on an iterative shift-add multiplier and stalls upstream stages (PC, IF/ID, ID/EX) while it is busy.
Inserts a bubble into EX/MEM for every stalled cycle.

Parameters:
XLEN, 32, datapath width
MUL_ITERS, 32, shift-add iterations for radix-2 (XLEN)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- valid_i  in  1  ID/EX holds a real instruction (0 = bubble)
- ALUOp_i  in  2  00 add, 01 sub, 10 R-type, 11 I-type ALU
- ALUSrc_i  in  1  1 = operand B is Imm_i
- Func10_i  in  10  {funct7, funct3}
- RS1data_i / RS2data_i  in  32  register-file operands
- Imm_i  in  32  sign-extended immediate
- ForwardA_i / ForwardB_i  in  2  00 reg, 10 MEM_ALUres_i, 01 WB_data_i, 11 treated as 00
- MEM_ALUres_i  in  32  EX/MEM ALU result
- WB_data_i  in  32  MEM/WB writeback data
- ALUres_o  out  32  result
- MemWdata_o  out  32  forwarded operand B before the ALUSrc mux (store data)
- Zero_o  out  1  ALUres_o == 0
- stall_o  out  1  freeze PC, IF/ID and ID/EX
- ex_valid_o  out  1  EX/MEM should capture this cycle; 0 means insert bubble

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset: FSM enters IDLE, counter 0, multiplicand/multiplier/product registers 0. While rst_i is high, ALUres_o, MemWdata_o, stall_o and ex_valid_o are 0, and Zero_o is 1.
- Forwarding is combinational. OpA = forward mux A. FwdB = forward mux B. OpB = ALUSrc_i ? Imm_i : FwdB. MemWdata_o = FwdB.
- Single-cycle ops, with result valid in the same cycle and ex_valid_o = valid_i:
  - ALUOp 00: add. ALUOp 01: sub.
  - ALUOp 10 (R-type): Func10 0000000_111 AND; 0000000_100 XOR; 0000000_001 SLL using OpB[4:0]; 0000000_000 ADD; 0100000_000 SUB.
  - ALUOp 11 (I-type): funct3 000 ADDI; funct3 101 with funct7 0100000 SRAI, arithmetic, by Imm_i[4:0].
  - Any other code gives result 0 and no error.
- All arithmetic is modulo 2^32.
- MUL (ALUOp 10, Func10 0000001_000, valid_i = 1) uses FSM states IDLE, RUN, DONE:
  - IDLE, MUL presented: stall_o = 1 combinationally and ex_valid_o = 0. At the edge, latch OpA/OpB (post-forwarding), clear product, counter = 0, go to RUN.
  - RUN: each cycle, if multiplier[0] then product += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++. stall_o = 1 and ex_valid_o = 0. After MUL_ITERS cycles, go to DONE.
  - DONE: stall_o = 0, ex_valid_o = 1, ALUres_o = product[31:0]. Go to IDLE at the next edge; ID/EX advances on the same edge.
- Timing: stall_o is high for exactly 33 consecutive cycles; the result appears in cycle 34.
- Forwarding or RS data changes during RUN are ignored because operands are latched.
- valid_i = 0 carrying MUL encoding: no FSM start.
- Reset during RUN or DONE aborts the multiply; stall_o is 0 in the cycle after reset deasserts.
- Non-MUL instructions are never seen in RUN/DONE, because ID/EX is frozen.

Optional Feature:
EX_MUL_RADIX4_EN
- Defined: the multiplier retires 2 bits per cycle, adding 0, 1×, 2× or 3× multiplicand (3× precomputed at latch). Shift is by 2, and there are 16 RUN cycles, so stall_o is high for 17 cycles and the result comes in cycle 18.
- Undefined: radix-2 as above.
- Results are identical in both modes.

Decomposition:
- Package ex_pkg: ALUOp codes, Func10 constants (FUNC_AND, FUNC_XOR, FUNC_SLL, FUNC_ADD, FUNC_SUB, FUNC_MUL, F3_ADDI, F3_SRAI), forward-select codes, FSM state enum (IDLE/RUN/DONE), and MUL_ITERS per radix.
- One sub-module, seq_multiplier, owns the FSM, counter and datapath with start/busy/done/product handshake. The forwarding, ALU and mux logic stays in ex_stage_seq.

Test Plan:
1. ADD: ALUOp=10, Func10=0, RS1=5, RS2=7, Fwd=00 -> ALUres_o=12 same cycle, stall_o=0, ex_valid_o=1, Zero_o=0.
2. Forward SUB: Func10=0100000_000, ForwardA=10 MEM_ALUres=100, ForwardB=01 WB=0xFFFFFFFD -> ALUres_o=103; MemWdata_o=0xFFFFFFFD.
3. MUL: OpA=0xFFFFFFFF, OpB=3 -> stall_o high 33 cycles (17 with EX_MUL_RADIX4_EN), ex_valid_o=0 throughout; DONE ALUres_o=0xFFFFFFFD, ex_valid_o=1 for one cycle.
4. MUL with ForwardA=10, MEM=6, RS2=7; MEM_ALUres_i changes to 99 after cycle 0 -> result 42.
5. Assert rst_i in RUN cycle 10 for one cycle -> all outputs 0 during reset; then ADD 1+1 completes in 1 cycle with stall_o=0.
6. SRAI: ALUOp=11, Func10=0100000_101, RS1=0x80000000, Imm=4 -> ALUres_o=0xF8000000; bubble (valid_i=0) carrying MUL encoding -> stall_o=0.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU op codes, Func10 values, forward selects,
// multiplier FSM states and iteration count (EX_MUL_RADIX4_EN selects the radix-4 count).
package ex_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  // Func10 is {funct7, funct3}
  localparam logic [9:0] FUNC_AND = 10'b0000000_111;
  localparam logic [9:0] FUNC_XOR = 10'b0000000_100;
  localparam logic [9:0] FUNC_SLL = 10'b0000000_001;
  localparam logic [9:0] FUNC_ADD = 10'b0000000_000;
  localparam logic [9:0] FUNC_SUB = 10'b0100000_000;
  localparam logic [9:0] FUNC_MUL = 10'b0000001_000;
  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_SRAI  = 3'b101;
  localparam logic [6:0] F7_SRA   = 7'b0100000;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mul_state_e;

`ifdef EX_MUL_RADIX4_EN
  localparam int MUL_ITERS_DEF = 16;
`else
  localparam int MUL_ITERS_DEF = 32;
`endif

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier with IDLE/RUN/DONE FSM; radix-2 by default,
// radix-4 (2 bits per cycle, 3x multiplicand precomputed) when EX_MUL_RADIX4_EN is defined.
module seq_multiplier
  import ex_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MUL_ITERS = MUL_ITERS_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] product_o,
  output logic [1:0]      state_o
);

  localparam int CNT_W = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  mcand_q, mplier_q, prod_q, addend;
  logic             last_iter;

  assign last_iter = (cnt_q == CNT_W'(MUL_ITERS - 1));

`ifdef EX_MUL_RADIX4_EN
  logic [XLEN-1:0] mcand3_q;

  always_comb begin
    addend = '0;
    case (mplier_q[1:0])
      2'b01:   addend = mcand_q;
      2'b10:   addend = mcand_q << 1;
      2'b11:   addend = mcand3_q;
      default: addend = '0;
    endcase
  end
`else
  always_comb begin
    addend = '0;
    if (mplier_q[0]) addend = mcand_q;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
`ifdef EX_MUL_RADIX4_EN
      mcand3_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i) begin
        mcand_q  <= a_i;
        mplier_q <= b_i;
        prod_q   <= '0;
        cnt_q    <= '0;
`ifdef EX_MUL_RADIX4_EN
        mcand3_q <= a_i + (a_i << 1);
`endif
      end else if (state_q == RUN) begin
        prod_q <= prod_q + addend;
        cnt_q  <= cnt_q + 1'b1;
`ifdef EX_MUL_RADIX4_EN
        mcand_q  <= mcand_q << 2;
        mcand3_q <= mcand3_q << 2;
        mplier_q <= mplier_q >> 2;
`else
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
`endif
      end
    end
  end

  assign busy_o    = (state_q == RUN);
  assign done_o    = (state_q == DONE);
  assign product_o = prod_q;
  assign state_o   = state_q;

endmodule

// File: rtl/ex_stage_seq.sv
// Execute stage: forwarding, ALUSrc mux, single-cycle ALU and a stalling sequential MUL.
// EX_MUL_RADIX4_EN shortens the multiply to 16 iterations (radix-4).
module ex_stage_seq
  import ex_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MUL_ITERS = MUL_ITERS_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [1:0]      ALUOp_i,
  input  logic            ALUSrc_i,
  input  logic [9:0]      Func10_i,
  input  logic [XLEN-1:0] RS1data_i,
  input  logic [XLEN-1:0] RS2data_i,
  input  logic [XLEN-1:0] Imm_i,
  input  logic [1:0]      ForwardA_i,
  input  logic [1:0]      ForwardB_i,
  input  logic [XLEN-1:0] MEM_ALUres_i,
  input  logic [XLEN-1:0] WB_data_i,
  output logic [XLEN-1:0] ALUres_o,
  output logic [XLEN-1:0] MemWdata_o,
  output logic            Zero_o,
  output logic            stall_o,
  output logic            ex_valid_o
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res, mul_product;
  logic            mul_req, mul_start, mul_busy, mul_done, mul_idle;
  logic [1:0]      mul_state;

  always_comb begin
    op_a = RS1data_i;
    case (ForwardA_i)
      FWD_MEM: op_a = MEM_ALUres_i;
      FWD_WB:  op_a = WB_data_i;
      default: op_a = RS1data_i;
    endcase
    fwd_b = RS2data_i;
    case (ForwardB_i)
      FWD_MEM: fwd_b = MEM_ALUres_i;
      FWD_WB:  fwd_b = WB_data_i;
      default: fwd_b = RS2data_i;
    endcase
  end

  assign op_b = ALUSrc_i ? Imm_i : fwd_b;

  always_comb begin
    alu_res = '0;
    case (ALUOp_i)
      ALUOP_ADD: alu_res = op_a + op_b;
      ALUOP_SUB: alu_res = op_a - op_b;
      ALUOP_RTYPE: begin
        case (Func10_i)
          FUNC_AND: alu_res = op_a & op_b;
          FUNC_XOR: alu_res = op_a ^ op_b;
          FUNC_SLL: alu_res = op_a << op_b[SHW-1:0];
          FUNC_ADD: alu_res = op_a + op_b;
          FUNC_SUB: alu_res = op_a - op_b;
          default:  alu_res = '0;
        endcase
      end
      ALUOP_ITYPE: begin
        if (Func10_i[2:0] == F3_ADDI)
          alu_res = op_a + op_b;
        else if (Func10_i[2:0] == F3_SRAI && Func10_i[9:3] == F7_SRA)
          alu_res = $signed(op_a) >>> Imm_i[SHW-1:0];
      end
      default: alu_res = '0;
    endcase
  end

  // Multiplier handshake: start is a one-cycle request honoured only in IDLE, where the
  // operands are captured; busy covers the iteration cycles; done is a one-cycle pulse
  // during which product is valid and EX/MEM captures it.
  assign mul_req   = valid_i && ALUOp_i == ALUOP_RTYPE && Func10_i == FUNC_MUL;
  assign mul_idle  = (mul_state == IDLE);
  assign mul_start = mul_req && mul_idle;

  seq_multiplier #(
    .XLEN      (XLEN),
    .MUL_ITERS (MUL_ITERS)
  ) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start),
    .a_i       (op_a),
    .b_i       (op_b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product),
    .state_o   (mul_state)
  );

  assign ALUres_o   = rst_i ? '0 : (mul_done ? mul_product : alu_res);
  assign MemWdata_o = rst_i ? '0 : fwd_b;
  assign Zero_o     = (ALUres_o == '0);
  assign stall_o    = !rst_i && (mul_start || mul_busy);
  assign ex_valid_o = !rst_i && (mul_done || (valid_i && !mul_req && mul_idle));

endmodule
